// File: rtl/loader_pkg.sv
// loader_pkg: shared widths and FSM states for the instruction memory loader
package loader_pkg;
    localparam int INSTR_W = 19;
    localparam int ADDR_W = 12;
    typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHK, DONE, ERR} state_t;
    function automatic logic accepts_byte(state_t s);
        return s inside {LEN_HI, LEN_LO, B0, B1, B2, CHK};
    endfunction
endpackage

// File: rtl/xor_accumulator.sv
// xor_accumulator: 8-bit running XOR with synchronous clear
module xor_accumulator (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) acc <= '0;
        else acc <= clr ? 8'h00 : en ? acc ^ din : acc;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams length-prefixed, checksummed instructions into IM and gates core reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int INSTR_LEN = INSTR_W,
    parameter int ADDR_LEN = ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 im_we,
    output logic [ADDR_LEN-1:0]  im_waddr,
    output logic [INSTR_LEN-1:0] im_wdata,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_LEN-1:0]  word_count
);
    state_t state;
    logic [ADDR_LEN-1:0] len;
    logic [INSTR_LEN-1:0] data;
    logic [7:0] acc;
    logic idle_like, take;
    assign idle_like = state inside {IDLE, DONE, ERR};
    assign byte_ready = accepts_byte(state);
    assign take = byte_valid && byte_ready;
    assign im_we = state == WRITE;
    assign im_waddr = word_count;
    assign im_wdata = data;
    xor_accumulator u_acc (
        .clk (clk),
        .rst (rst),
        .clr (idle_like && start),
        .en  (take && state != CHK),
        .din (byte_data),
        .acc (acc)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            len <= '0;
            data <= '0;
            word_count <= '0;
            core_hold <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state <= LEN_HI;
                    done <= 1'b0;
                    error <= 1'b0;
                    word_count <= '0;
                    busy <= 1'b1;
                    core_hold <= 1'b1;
                end
                LEN_HI: if (byte_valid) begin
                    if (byte_data[7:4] != 4'h0) begin
                        state <= ERR;
                        busy <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        len[11:8] <= byte_data[3:0];
                        state <= LEN_LO;
                    end
                end
                LEN_LO: if (byte_valid) begin
                    len[7:0] <= byte_data;
                    state <= {len[11:8], byte_data} == 12'd0 ? CHK : B0;
                end
                B0: if (byte_valid) begin
                    if (byte_data[7:3] != 5'd0) begin
                        state <= ERR;
                        busy <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        data[18:16] <= byte_data[2:0];
                        state <= B1;
                    end
                end
                B1: if (byte_valid) begin
                    data[15:8] <= byte_data;
                    state <= B2;
                end
                B2: if (byte_valid) begin
                    data[7:0] <= byte_data;
                    state <= WRITE;
                end
                WRITE: begin
                    word_count <= word_count + 1'b1;
                    state <= ADDR_LEN'(word_count + 1'b1) == len ? CHK : B0;
                end
                CHK: if (byte_valid) begin
                    busy <= 1'b0;
                    if (byte_data == acc) begin
                        state <= DONE;
                        done <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state <= ERR;
                        error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of stream parsing, IM writes, checksum and reset
module tb_imem_loader;
    logic clk = 0, rst = 0, start = 0, byte_valid = 0;
    logic [7:0] byte_data = 0;
    logic byte_ready, im_we, core_hold, busy, done, error;
    logic [11:0] im_waddr, word_count;
    logic [18:0] im_wdata;
    int checks = 0, failures = 0, nw = 0;
    logic [11:0] wa [0:63];
    logic [18:0] wd [0:63];
    logic [7:0] stream [0:8];

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (im_we && nw < 64) begin
            wa[nw] = im_waddr;
            wd[nw] = im_wdata;
            nw++;
        end

    task automatic pulse_start();
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        byte_valid = 1;
        byte_data = b;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (byte_ready) break;
            n++;
        end
        checks++;
        if (n == 50) begin
            failures++;
            $display("FAIL send_timeout byte=%h never accepted", b);
        end else begin
            @(posedge clk);
            #1;
        end
        byte_valid = 0;
    endtask

    task automatic send_seq(input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) send(stream[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic check_status(input string nm, input logic e_done, input logic e_err,
                                input logic e_hold, input logic e_busy, input logic [11:0] e_wc);
        checks++;
        if ({done, error, core_hold, busy, word_count} !== {e_done, e_err, e_hold, e_busy, e_wc}) begin
            failures++;
            $display("FAIL %s got done=%b err=%b hold=%b busy=%b wc=%0d want done=%b err=%b hold=%b busy=%b wc=%0d",
                     nm, done, error, core_hold, busy, word_count, e_done, e_err, e_hold, e_busy, e_wc);
        end
    endtask

    task automatic check_writes(input string nm, input int base, input int cnt);
        checks++;
        if (nw - base !== cnt) begin
            failures++;
            $display("FAIL %s_count got %0d writes want %0d", nm, nw - base, cnt);
        end
    endtask

    task automatic check_two_words(input string nm, input int base);
        checks++;
        if (wa[base] !== 12'd0 || wd[base] !== 19'h1ABCD) begin
            failures++;
            $display("FAIL %s_w0 got addr=%h data=%h want addr=000 data=1abcd", nm, wa[base], wd[base]);
        end
        checks++;
        if (wa[base+1] !== 12'd1 || wd[base+1] !== 19'h00007) begin
            failures++;
            $display("FAIL %s_w1 got addr=%h data=%h want addr=001 data=00007", nm, wa[base+1], wd[base+1]);
        end
    endtask

    task automatic check_reset_values(input string nm);
        checks++;
        if ({byte_ready, im_we, im_waddr, im_wdata, core_hold, busy, done, error, word_count} !==
            {1'b0, 1'b0, 12'd0, 19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0}) begin
            failures++;
            $display("FAIL %s got rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b wc=%0d want reset values",
                     nm, byte_ready, im_we, im_waddr, im_wdata, core_hold, busy, done, error, word_count);
        end
    endtask

    task automatic load_good_stream();
        stream = '{8'h00, 8'h02, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h07, 8'h62};
    endtask

    task automatic test_reset();
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1;
        check_reset_values("idle_after_release");
    endtask

    task automatic test_good_load();
        int base = nw;
        load_good_stream();
        pulse_start();
        check_status("busy_after_start", 0, 0, 1, 1, 0);
        send_seq(9, 0);
        check_writes("good", base, 2);
        check_two_words("good", base);
        check_status("good_status", 1, 0, 0, 0, 2);
    endtask

    task automatic test_bad_checksum();
        int base = nw;
        load_good_stream();
        stream[8] = 8'h63;
        pulse_start();
        send_seq(9, 0);
        check_writes("badchk", base, 2);
        check_status("badchk_status", 0, 1, 1, 0, 2);
    endtask

    task automatic test_b0_error();
        int base = nw;
        stream = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_seq(3, 0);
        check_status("b0err_status", 0, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_writes("b0err", base, 0);
        checks++;
        if (byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL b0err_ready got %b want 0", byte_ready);
        end
    endtask

    task automatic test_header_error();
        pulse_start();
        send(8'h10, 0);
        check_status("hdrerr_status", 0, 1, 1, 0, 0);
    endtask

    task automatic test_zero_length();
        int base = nw;
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_seq(3, 0);
        check_status("zero_status", 1, 0, 0, 0, 0);
        check_writes("zero", base, 0);
    endtask

    task automatic test_async_reset();
        int base = nw;
        load_good_stream();
        pulse_start();
        send_seq(4, 0);
        #2 rst = 0;
        #1;
        check_reset_values("async_reset");
        check_writes("async", base, 0);
        @(posedge clk);
        #1 rst = 1;
        base = nw;
        pulse_start();
        send_seq(9, 0);
        check_writes("after_reset", base, 2);
        check_two_words("after_reset", base);
        check_status("after_reset_status", 1, 0, 0, 0, 2);
    endtask

    task automatic test_gaps_and_start();
        int base = nw;
        load_good_stream();
        pulse_start();
        send_seq(4, 1);
        pulse_start();
        check_status("busy_mid_load", 0, 0, 1, 1, 0);
        for (int i = 4; i < 9; i++) send(stream[i], int'($urandom_range(0, 3)));
        check_writes("gaps", base, 2);
        check_two_words("gaps", base);
        check_status("gaps_status", 1, 0, 0, 0, 2);
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_b0_error();
        test_header_error();
        test_zero_length();
        test_async_reset();
        test_gaps_and_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
